// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Passive receiver for a multiplexed 4-digit seven-segment bus. It samples the
// digit-select and segment lines and decodes each stable digit back to BCD.
// Once all four digits have been captured it publishes a frame, together with
// the binary seconds and minutes rebuilt from the digit pairs.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active low
//   sel[3:0]     digit select pins (0 = unit, 1 = ten, 2 = hun, 3 = tho)
//   seg[6:0]     segment pins (bit 0 = a .. bit 6 = g)
//   unit/ten/hun/tho[3:0]  last published frame, BCD (4'hF = undecodable)
//   sec[5:0]     ten*10 + unit, 6'h3F when out of range
//   min[5:0]     tho*10 + hun,  6'h3F when out of range
//   frame_valid  one-cycle pulse when a new frame is published
//   err          one-cycle pulse on a decode or range error
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sel,
  input  logic [6:0] seg,
  output logic [3:0] unit,
  output logic [3:0] ten,
  output logic [3:0] hun,
  output logic [3:0] tho,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic       frame_valid,
  output logic       err
);

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned DIG_W      = 4;
  localparam int unsigned BIN_W      = 6;
  localparam int unsigned CNT_W      = 8;

  localparam logic [CNT_W-1:0] CAP_CNT  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [DIG_W-1:0] DIG_BAD  = 4'hF;
  localparam logic [BIN_W-1:0] BIN_BAD  = 6'h3F;
  localparam logic [SEL_W-1:0] ALL_DONE = 4'b1111;

  // Two-flop synchronizers for the asynchronous pins
  logic [SEL_W-1:0] r_sel_s1, r_sel_s2;
  logic [SEG_W-1:0] r_seg_s1, r_seg_s2;

  // Previous-cycle normalized values for change detection
  logic [SEL_W-1:0] r_sel_p;
  logic [SEG_W-1:0] r_seg_p;

  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;
  logic [SEL_W-1:0] r_collected;
  logic [DIG_W-1:0] r_shadow [NUM_DIGITS];

  logic [SEL_W-1:0] w_sel_n;
  logic [SEG_W-1:0] w_seg_n;
  logic             w_onehot;
  logic             w_change;
  logic             w_capture;
  logic [DIG_W-1:0] w_dec;
  logic             w_dec_err;
  logic             w_publish;
  logic             w_sec_bad;
  logic             w_min_bad;
  logic [BIN_W-1:0] w_sec_bin;
  logic [BIN_W-1:0] w_min_bin;

  // Seven-segment (active-high gfedcba) to BCD; anything else is undecodable
  function automatic logic [DIG_W-1:0] seg_to_bcd(input logic [SEG_W-1:0] p);
    logic [DIG_W-1:0] d;
    case (p)
      7'h3F:   d = 4'd0;
      7'h06:   d = 4'd1;
      7'h5B:   d = 4'd2;
      7'h4F:   d = 4'd3;
      7'h66:   d = 4'd4;
      7'h6D:   d = 4'd5;
      7'h7D:   d = 4'd6;
      7'h07:   d = 4'd7;
      7'h7F:   d = 4'd8;
      7'h6F:   d = 4'd9;
      default: d = DIG_BAD;
    endcase
    return d;
  endfunction

  // A tens/units pair is usable only if both are BCD and the tens digit is 0..5
  function automatic logic pair_bad(input logic [DIG_W-1:0] t,
                                    input logic [DIG_W-1:0] u);
    return (t > 4'd5) || (u > 4'd9);
  endfunction

  function automatic logic [BIN_W-1:0] pair_bin(input logic [DIG_W-1:0] t,
                                                input logic [DIG_W-1:0] u);
    return BIN_W'(t) * BIN_W'(10) + BIN_W'(u);
  endfunction

  // Input conditioning and qualification
  always_comb begin
    w_sel_n   = r_sel_s2 ^ {SEL_W{SEL_ACTIVE_LOW}};
    w_seg_n   = r_seg_s2 ^ {SEG_W{SEG_ACTIVE_LOW}};
    w_onehot  = (w_sel_n != '0) && ((w_sel_n & (w_sel_n - SEL_W'(1))) == '0);
    w_change  = (w_sel_n != r_sel_p) || (w_seg_n != r_seg_p);
    // Counter reaches CAP_CNT only after STABLE_CYCLES unchanged cycles
    w_capture = w_onehot && !w_change && !r_armed && (r_cnt == CAP_CNT);
    w_dec     = seg_to_bcd(w_seg_n);
    w_dec_err = (w_dec == DIG_BAD);
  end

  // Frame publication and binary reconstruction from the shadows
  always_comb begin
    w_publish = (r_collected == ALL_DONE);
    w_sec_bad = pair_bad(r_shadow[1], r_shadow[0]);
    w_min_bad = pair_bad(r_shadow[3], r_shadow[2]);
    w_sec_bin = w_sec_bad ? BIN_BAD : pair_bin(r_shadow[1], r_shadow[0]);
    w_min_bin = w_min_bad ? BIN_BAD : pair_bin(r_shadow[3], r_shadow[2]);
  end

  // Synchronizer and change-detect history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sel_s1 <= '0;
      r_sel_s2 <= '0;
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
      r_sel_p  <= '0;
      r_seg_p  <= '0;
    end else begin
      r_sel_s1 <= sel;
      r_sel_s2 <= r_sel_s1;
      r_seg_s1 <= seg;
      r_seg_s2 <= r_seg_s1;
      r_sel_p  <= w_sel_n;
      r_seg_p  <= w_seg_n;
    end
  end

  // Stability counter and one-capture-per-activation guard
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_armed <= 1'b0;
    end else begin
      if (!w_onehot || w_change) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if (w_change) begin
        r_armed <= 1'b0;
      end else if (w_capture) begin
        r_armed <= 1'b1;
      end
    end
  end

  // Shadow digits and collection mask; a publish clears the mask
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_collected <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      r_collected <= (w_publish ? '0 : r_collected) |
                     (w_capture ? w_sel_n : '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && w_sel_n[i]) begin
          r_shadow[i] <= w_dec;
        end
      end
    end
  end

  // Registered frame outputs and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unit        <= '0;
      ten         <= '0;
      hun         <= '0;
      tho         <= '0;
      sec         <= '0;
      min         <= '0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_valid <= w_publish;
      // Decode and range errors landing in one cycle merge into one pulse
      err         <= (w_capture && w_dec_err) ||
                     (w_publish && (w_sec_bad || w_min_bad));
      if (w_publish) begin
        unit <= r_shadow[0];
        ten  <= r_shadow[1];
        hun  <= r_shadow[2];
        tho  <= r_shadow[3];
        sec  <= w_sec_bin;
        min  <= w_min_bin;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives active-low scan patterns,
// pushes the expected frame into a scoreboard queue and compares every
// published frame against it.
module tb_seg_scan_decoder;

  localparam int unsigned STABLE = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sel;
  logic [6:0] seg;
  logic [3:0] unit, ten, hun, tho;
  logic [5:0] sec, min;
  logic       frame_valid, err;

  typedef struct {
    logic [3:0] u, t, h, th;
    logic [5:0] s, m;
  } exp_t;

  exp_t exp_q[$];
  int   checks      = 0;
  int   errors      = 0;
  int   frames_seen = 0;
  int   exp_frames  = 0;
  int   err_seen    = 0;

  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  seg_scan_decoder #(
    .STABLE_CYCLES (STABLE),
    .SEL_ACTIVE_LOW(1'b1),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel),
    .seg        (seg),
    .unit       (unit),
    .ten        (ten),
    .hun        (hun),
    .tho        (tho),
    .sec        (sec),
    .min        (min),
    .frame_valid(frame_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: digits in, expected frame out
  function automatic exp_t make_exp(input logic [3:0] u, t, h, th);
    exp_t e;
    e.u = u; e.t = t; e.h = h; e.th = th;
    e.s = (t > 5 || u > 9) ? 6'h3F : 6'(t * 10 + u);
    e.m = (th > 5 || h > 9) ? 6'h3F : 6'(th * 10 + h);
    return e;
  endfunction

  task automatic push_exp(input logic [3:0] u, t, h, th);
    exp_q.push_back(make_exp(u, t, h, th));
    exp_frames++;
  endtask

  // Scoreboard monitor, sampling on the inactive edge
  always @(negedge clk) begin
    exp_t e;
    if (err === 1'b1) err_seen++;
    if (frame_valid === 1'b1) begin
      frames_seen++;
      chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("unit", 32'(unit), 32'(e.u));
        chk("ten",  32'(ten),  32'(e.t));
        chk("hun",  32'(hun),  32'(e.h));
        chk("tho",  32'(tho),  32'(e.th));
        chk("sec",  32'(sec),  32'(e.s));
        chk("min",  32'(min),  32'(e.m));
      end
    end
  end

  // Hold normalized (active-high) sel/seg on the active-low pins for n clocks
  task automatic put(input logic [3:0] sel_h, input logic [6:0] seg_h, input int n);
    sel = ~sel_h;
    seg = ~seg_h;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scan(input logic [6:0] pu, pt, ph, pth, input int dwell);
    put(4'b0000, 7'h00, 2);
    put(4'b0001, pu, dwell);
    put(4'b0000, 7'h00, 2);
    put(4'b0010, pt, dwell);
    put(4'b0000, 7'h00, 2);
    put(4'b0100, ph, dwell);
    put(4'b0000, 7'h00, 2);
    put(4'b1000, pth, dwell);
  endtask

  task automatic wait_frames(input string tag);
    int n = 0;
    while (frames_seen < exp_frames && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk(tag, 32'(frames_seen), 32'(exp_frames));
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk);
    chk({tag, "_digits"}, {16'h0, unit, ten, hun, tho}, 32'h0);
    chk({tag, "_bin"}, {20'h0, sec, min}, 32'h0);
    chk({tag, "_flags"}, {30'h0, frame_valid, err}, 32'h0);
  endtask

  initial begin
    int e0, f0;
    rst = 1'b0;
    sel = 4'hF;
    seg = 7'h7F;
    repeat (3) @(posedge clk);
    chk_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b1;

    // Basic frame 1,2,3,4
    e0 = err_seen;
    push_exp(4'd1, 4'd2, 4'd3, 4'd4);
    scan(pat[1], pat[2], pat[3], pat[4], 100);
    wait_frames("frame_basic");
    chk("err_basic", 32'(err_seen - e0), 32'd0);

    // Too-short dwell: nothing captured, outputs untouched
    f0 = frames_seen;
    scan(pat[7], pat[7], pat[7], pat[7], STABLE - 2);
    put(4'b0000, 7'h00, 30);
    chk("no_frame_short_dwell", 32'(frames_seen), 32'(f0));
    chk("hold_after_short", {16'h0, unit, ten, hun, tho}, 32'h1234);
    push_exp(4'd5, 4'd4, 4'd3, 4'd2);
    scan(pat[5], pat[4], pat[3], pat[2], 100);
    wait_frames("frame_after_short");

    // Blank on hun: decode err at capture, range err at publish
    e0 = err_seen;
    push_exp(4'd1, 4'd2, 4'hF, 4'd3);
    scan(pat[1], pat[2], 7'h00, pat[3], 100);
    wait_frames("frame_blank");
    chk("err_blank", 32'(err_seen - e0), 32'd2);

    // ten=7 decodes fine but sec is out of range
    e0 = err_seen;
    push_exp(4'd0, 4'd7, 4'd9, 4'd5);
    scan(pat[0], pat[7], pat[9], pat[5], 100);
    wait_frames("frame_ten7");
    chk("err_ten7", 32'(err_seen - e0), 32'd1);

    // Multi-hot select glitch between digits
    e0 = err_seen;
    push_exp(4'd8, 4'd1, 4'd2, 4'd0);
    put(4'b0001, pat[8], 100);
    put(4'b0110, pat[3], 3);
    put(4'b0010, pat[1], 100);
    put(4'b0110, 7'h00, 3);
    put(4'b0100, pat[2], 100);
    put(4'b1000, pat[0], 100);
    wait_frames("frame_glitch");
    chk("err_glitch", 32'(err_seen - e0), 32'd0);

    // Reset after two digits: partial frame must be discarded
    put(4'b0000, 7'h00, 2);
    put(4'b0001, pat[9], 100);
    put(4'b0010, pat[3], 100);
    rst = 1'b0;
    sel = 4'hF;
    seg = 7'h7F;
    chk_zero("mid_reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    f0 = frames_seen;
    e0 = err_seen;
    put(4'b0000, 7'h00, 4);
    chk("no_frame_after_reset", 32'(frames_seen), 32'(f0));
    push_exp(4'd6, 4'd5, 4'd4, 4'd1);
    scan(pat[6], pat[5], pat[4], pat[1], 100);
    wait_frames("frame_post_reset");
    chk("err_post_reset", 32'(err_seen - e0), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
